// File: rtl/exec_unit_pkg.sv
// exec_unit_pkg: opcode constants and ALU/FPU operation encodings shared by the execute stage
package exec_unit_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00001;
    localparam logic [4:0] OP_ANDI  = 5'b00010;
    localparam logic [4:0] OP_ORI   = 5'b00011;
    localparam logic [4:0] OP_XORI  = 5'b00100;
    localparam logic [4:0] OP_SLTI  = 5'b00101;
    localparam logic [4:0] OP_LD    = 5'b00110;
    localparam logic [4:0] OP_ST    = 5'b00111;
    localparam logic [4:0] OP_BEQ   = 5'b01000;
    localparam logic [4:0] OP_BNE   = 5'b01001;
    localparam logic [4:0] OP_BLT   = 5'b01010;
    localparam logic [4:0] OP_J     = 5'b01100;
    localparam logic [4:0] OP_JR    = 5'b01110;
    localparam logic [4:0] OP_FPU   = 5'b10000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLL, ALU_SRL,
        ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MULT, ALU_MFHI, ALU_MFLO, ALU_EQ, ALU_NE
    } alu_op_e;

    typedef enum logic [1:0] {FPU_ADD, FPU_SUB, FPU_MUL, FPU_LT} fpu_op_e;

endpackage

// File: rtl/exec_unit_if.sv
// exec_if: instruction/operand inputs and decoded/ALU results of the execute stage
interface exec_if;
    import exec_unit_pkg::*;

    logic [31:0] ir;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        i_r;
    logic        write_reg_en;
    logic        regfile_src_oalu_st;
    logic        jump;
    logic        wr_en_stk;
    logic        br_inst;
    logic        fen;
    alu_op_e     alu_inst;
    fpu_op_e     flopinst;
    logic [31:0] o;
    logic        cout;
    logic        overflow;
    logic        alu_go_ahead;
    logic        branch;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] f0;

    modport master (
        output ir, rs_val, rt_val,
        input  i_r, write_reg_en, regfile_src_oalu_st, jump, wr_en_stk, br_inst, fen,
        input  alu_inst, flopinst, o, cout, overflow, alu_go_ahead, branch, hi, lo, f0
    );

    modport slave (
        input  ir, rs_val, rt_val,
        output i_r, write_reg_en, regfile_src_oalu_st, jump, wr_en_stk, br_inst, fen,
        output alu_inst, flopinst, o, cout, overflow, alu_go_ahead, branch, hi, lo, f0
    );

endinterface

// File: rtl/exec_fpu.sv
// exec_fpu: combinational single-precision add/sub/mul/less-than, truncating, denormals flushed
module exec_fpu
    import exec_unit_pkg::*;
(
    input  fpu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic              za, zb, sa, sb, sw, sx, sy, lt;
    logic [30:0]       mag_a, mag_b;
    logic [23:0]       ma, mb, mx, my;
    logic signed [9:0] ea, eb, ex, ey, em, es;
    logic [47:0]       p;
    logic [7:0]        d;
    logic [5:0]        ds, lead, lz;
    logic [99:0]       ext;
    logic [50:0]       bx, by, s;
    logic [49:0]       norm;
    logic [31:0]       mul_y, add_y;
    logic              unused_fpu;

    // Exponent out of range saturates to infinity or flushes to signed zero
    function automatic logic [31:0] pack(logic sg, logic signed [9:0] e, logic [22:0] m);
        return e >= 10'sd255 ? {sg, 8'hFF, 23'd0} : e <= 10'sd0 ? {sg, 31'd0} : {sg, e[7:0], m};
    endfunction

    // Unpack, then compute all three arithmetic paths and select by op
    always_comb begin
        za = a[30:23] == 8'd0;
        zb = b[30:23] == 8'd0;
        mag_a = za ? 31'd0 : a[30:0];
        mag_b = zb ? 31'd0 : b[30:0];
        sa = a[31];
        sb = b[31] ^ (op == FPU_SUB);
        ma = za ? 24'd0 : {1'b1, a[22:0]};
        mb = zb ? 24'd0 : {1'b1, b[22:0]};
        ea = $signed({2'b00, a[30:23]});
        eb = $signed({2'b00, b[30:23]});
        p = {24'd0, ma} * {24'd0, mb};
        em = ea + eb - 10'sd127 + (p[47] ? 10'sd1 : 10'sd0);
        mul_y = (za | zb) ? {sa ^ sb, 31'd0} : pack(sa ^ sb, em, p[47] ? p[46:24] : p[45:23]);
        sw = mag_b > mag_a;
        sx = sw ? sb : sa;
        sy = sw ? sa : sb;
        mx = sw ? mb : ma;
        my = sw ? ma : mb;
        ex = sw ? eb : ea;
        ey = sw ? ea : eb;
        d = 8'(ex - ey);
        ds = d > 8'd50 ? 6'd50 : d[5:0];
        ext = {my, 76'd0} >> ds;
        bx = {1'b0, mx, 26'd0};
        by = {1'b0, ext[99:50]} | {50'd0, |ext[49:0]};
        s = (sx ^ sy) ? bx - by : bx + by;
        lead = 6'd0;
        for (int i = 0; i < 50; i++) if (s[i]) lead = 6'(i);
        lz = 6'd49 - lead;
        norm = s[49:0] << lz;
        es = s[50] ? ex + 10'sd1 : ex - $signed({4'd0, lz});
        add_y = s == 51'd0 ? 32'd0 : pack(sx, es, s[50] ? s[49:27] : norm[48:26]);
        lt = (sa & ~za) != (b[31] & ~zb) ? (sa & ~za) : (sa & ~za) ? mag_a > mag_b : mag_a < mag_b;
        y = op == FPU_LT ? (lt ? 32'h3F80_0000 : 32'd0) : op == FPU_MUL ? mul_y : add_y;
    end

    assign unused_fpu = ^{p[22:0], norm[49], norm[25:0]};

endmodule

// File: rtl/exec_unit.sv
// exec_unit: instruction decode, 32-bit ALU, HI/LO multiply registers and FPU result register
module exec_unit
    import exec_unit_pkg::*;
(
    input logic   clk,
    input logic   rst,
    exec_if.slave bus
);

    logic [4:0]  opc;
    logic        i_r, wre, src, jump, stk, br, fen, cout, ovf, go;
    alu_op_e     op;
    logic [31:0] a, b, o, fpu_y;
    logic [32:0] sum, dif;
    logic [63:0] prod;
    logic [31:0] hi_d, hi_q, lo_d, lo_q, f0_d, f0_q;
    logic        unused_ir;

    assign opc = bus.ir[31:27];
    assign a = bus.rs_val;

    // Decode: every strobe defaults low and ALU op defaults to ADD
    always_comb begin
        i_r = 1'b0;
        wre = 1'b0;
        src = 1'b0;
        jump = 1'b0;
        stk = 1'b0;
        br = 1'b0;
        fen = 1'b0;
        op = ALU_ADD;
        case (opc)
            OP_RTYPE: begin
                op = alu_op_e'(bus.ir[3:0]);
                i_r = 1'b1;
                wre = 1'b1;
                src = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
                wre = 1'b1;
                src = 1'b1;
                op = opc == OP_ANDI ? ALU_AND : opc == OP_ORI ? ALU_OR :
                     opc == OP_XORI ? ALU_XOR : opc == OP_SLTI ? ALU_SLT : ALU_ADD;
            end
            OP_LD: wre = 1'b1;
            OP_ST: stk = 1'b1;
            OP_BEQ, OP_BNE, OP_BLT: begin
                i_r = 1'b1;
                br = 1'b1;
                op = opc == OP_BEQ ? ALU_EQ : opc == OP_BNE ? ALU_NE : ALU_SLT;
            end
            OP_J, OP_JR: jump = 1'b1;
            OP_FPU: fen = 1'b1;
            default: ;
        endcase
    end

    // ALU: operand select, result mux and flags
    always_comb begin
        b = i_r ? bus.rt_val : {{16{bus.ir[15]}}, bus.ir[15:0]};
        sum = {1'b0, a} + {1'b0, b};
        dif = {1'b0, a} + {1'b0, ~b} + 33'd1;
        prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        o = sum[31:0];
        case (op)
            ALU_SUB:  o = dif[31:0];
            ALU_AND:  o = a & b;
            ALU_OR:   o = a | b;
            ALU_XOR:  o = a ^ b;
            ALU_NOR:  o = ~(a | b);
            ALU_SLL:  o = a << b[4:0];
            ALU_SRL:  o = a >> b[4:0];
            ALU_SRA:  o = 32'($signed(a) >>> b[4:0]);
            ALU_SLT:  o = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: o = {31'd0, a < b};
            ALU_MULT: o = prod[31:0];
            ALU_MFHI: o = hi_q;
            ALU_MFLO: o = lo_q;
            ALU_EQ:   o = {31'd0, a == b};
            ALU_NE:   o = {31'd0, a != b};
            default:  ;
        endcase
        cout = op == ALU_ADD ? sum[32] : op == ALU_SUB ? dif[32] : 1'b0;
        ovf = op == ALU_ADD ? (a[31] == b[31]) && (sum[31] != a[31]) :
              op == ALU_SUB ? (a[31] != b[31]) && (dif[31] != a[31]) : 1'b0;
        go = (op == ALU_EQ || op == ALU_NE || op == ALU_SLT) && o[0];
    end

    exec_fpu u_fpu (
        .op(fpu_op_e'(bus.ir[1:0])),
        .a (bus.rs_val),
        .b (bus.rt_val),
        .y (fpu_y)
    );

    // Next state: MULT loads HI/LO, FPU op loads f0, otherwise hold
    always_comb begin
        hi_d = op == ALU_MULT ? prod[63:32] : hi_q;
        lo_d = op == ALU_MULT ? prod[31:0] : lo_q;
        f0_d = fen ? fpu_y : f0_q;
    end

    // Result registers, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
            f0_q <= 32'd0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            f0_q <= f0_d;
        end
    end

    assign bus.i_r = i_r;
    assign bus.write_reg_en = wre;
    assign bus.regfile_src_oalu_st = src;
    assign bus.jump = jump;
    assign bus.wr_en_stk = stk;
    assign bus.br_inst = br;
    assign bus.fen = fen;
    assign bus.alu_inst = op;
    assign bus.flopinst = fen ? fpu_op_e'(bus.ir[1:0]) : FPU_ADD;
    assign bus.o = o;
    assign bus.cout = cout;
    assign bus.overflow = ovf;
    assign bus.alu_go_ahead = go;
    assign bus.branch = br & go;
    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
    assign bus.f0 = f0_q;
    assign unused_ir = ^bus.ir[26:16];

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed and random checks of exec_unit against a behavioural model
module tb_exec_unit;
    import exec_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_f0 = 32'd0;
    logic [4:0]  ops [15] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                             5'd8, 5'd9, 5'd10, 5'd12, 5'd14, 5'd16, 5'd0};

    exec_if bus();
    exec_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic real f2r(logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return f[31] ? -0.0 : 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        if (r == 0.0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_ref(logic [1:0] fop, logic [31:0] x, logic [31:0] y);
        real rx, ry;
        rx = f2r(x);
        ry = f2r(y);
        case (fop)
            2'd0: return r2f(rx + ry);
            2'd1: return r2f(rx - ry);
            2'd2: return r2f(rx * ry);
            default: return rx < ry ? 32'h3F80_0000 : 32'd0;
        endcase
    endfunction

    task automatic alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] o, output logic c, output logic v);
        longint sa, sb, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        o = 32'd0;
        case (op)
            4'd0: begin
                u = 64'(a) + 64'(b);
                o = u[31:0];
                c = u[32];
                r = sa + sb;
                v = r > 64'sd2147483647 || r < -64'sd2147483648;
            end
            4'd1: begin
                o = a - b;
                c = a >= b;
                r = sa - sb;
                v = r > 64'sd2147483647 || r < -64'sd2147483648;
            end
            4'd2: o = a & b;
            4'd3: o = a | b;
            4'd4: o = a ^ b;
            4'd5: o = ~(a | b);
            4'd6: o = a << b[4:0];
            4'd7: o = a >> b[4:0];
            4'd8: begin
                r = sa >>> b[4:0];
                o = r[31:0];
            end
            4'd9: o = sa < sb ? 32'd1 : 32'd0;
            4'd10: o = a < b ? 32'd1 : 32'd0;
            4'd11: begin
                r = sa * sb;
                o = r[31:0];
            end
            4'd12: o = m_hi;
            4'd13: o = m_lo;
            4'd14: o = a == b ? 32'd1 : 32'd0;
            default: o = a != b ? 32'd1 : 32'd0;
        endcase
    endtask

    task automatic run(input logic [31:0] ir_v, input logic [31:0] rs, input logic [31:0] rt);
        logic [4:0] opc;
        logic e_ir, e_wre, e_src, e_j, e_stk, e_br, e_fen, e_c, e_v, e_go;
        logic [3:0] e_op;
        logic [1:0] e_fop;
        logic [31:0] b, e_o;
        longint p;
        opc = ir_v[31:27];
        {e_ir, e_wre, e_src, e_j, e_stk, e_br, e_fen} = 7'd0;
        e_op = 4'd0;
        e_fop = 2'd0;
        if (opc == 5'd0) begin
            e_op = ir_v[3:0];
            {e_ir, e_wre, e_src} = 3'b111;
        end else if (opc >= 5'd1 && opc <= 5'd5) begin
            {e_wre, e_src} = 2'b11;
            e_op = opc == 5'd1 ? 4'd0 : opc == 5'd2 ? 4'd2 : opc == 5'd3 ? 4'd3 : opc == 5'd4 ? 4'd4 : 4'd9;
        end else if (opc == 5'd6) e_wre = 1'b1;
        else if (opc == 5'd7) e_stk = 1'b1;
        else if (opc >= 5'd8 && opc <= 5'd10) begin
            {e_ir, e_br} = 2'b11;
            e_op = opc == 5'd8 ? 4'd14 : opc == 5'd9 ? 4'd15 : 4'd9;
        end else if (opc == 5'd12 || opc == 5'd14) e_j = 1'b1;
        else if (opc == 5'd16) begin
            e_fen = 1'b1;
            e_fop = ir_v[1:0];
        end
        b = e_ir ? rt : {{16{ir_v[15]}}, ir_v[15:0]};
        alu_ref(e_op, rs, b, e_o, e_c, e_v);
        e_go = (e_op == 4'd9 || e_op == 4'd14 || e_op == 4'd15) && e_o[0];
        bus.ir = ir_v;
        bus.rs_val = rs;
        bus.rt_val = rt;
        #1;
        chk($sformatf("i_r[%h]", ir_v), bus.i_r, e_ir);
        chk($sformatf("wre[%h]", ir_v), bus.write_reg_en, e_wre);
        chk($sformatf("src[%h]", ir_v), bus.regfile_src_oalu_st, e_src);
        chk($sformatf("jump[%h]", ir_v), bus.jump, e_j);
        chk($sformatf("stk[%h]", ir_v), bus.wr_en_stk, e_stk);
        chk($sformatf("br[%h]", ir_v), bus.br_inst, e_br);
        chk($sformatf("fen[%h]", ir_v), bus.fen, e_fen);
        chk($sformatf("alu_inst[%h]", ir_v), bus.alu_inst, e_op);
        chk($sformatf("flopinst[%h]", ir_v), bus.flopinst, e_fop);
        chk($sformatf("o[%h %h %h]", ir_v, rs, rt), bus.o, e_o);
        chk($sformatf("cout[%h %h %h]", ir_v, rs, rt), bus.cout, e_c);
        chk($sformatf("ovf[%h %h %h]", ir_v, rs, rt), bus.overflow, e_v);
        chk($sformatf("go[%h %h %h]", ir_v, rs, rt), bus.alu_go_ahead, e_go);
        chk($sformatf("branch[%h %h %h]", ir_v, rs, rt), bus.branch, e_br & e_go);
        @(posedge clk);
        #1;
        if (e_op == 4'd11) begin
            p = longint'($signed(rs)) * longint'($signed(b));
            {m_hi, m_lo} = p;
        end
        if (e_fen) m_f0 = fpu_ref(ir_v[1:0], rs, rt);
        chk($sformatf("hi[%h]", ir_v), bus.hi, m_hi);
        chk($sformatf("lo[%h]", ir_v), bus.lo, m_lo);
        chk($sformatf("f0[%h %h %h]", ir_v, rs, rt), bus.f0, m_f0);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        e = 8'(120 + $urandom_range(0, 15));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    initial begin
        logic [4:0] opc;
        logic [31:0] rs, rt;
        bus.ir = 32'd0;
        bus.rs_val = 32'd0;
        bus.rt_val = 32'd0;
        #2;
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_f0", bus.f0, 32'd0);
        #10 rst = 1'b1;
        run({5'd0, 23'd0, 4'd0}, 32'h7FFF_FFFF, 32'd1);
        chk("add_ovf_o", bus.o, 32'h8000_0000);
        chk("add_ovf_v", bus.overflow, 1'b1);
        chk("add_ovf_c", bus.cout, 1'b0);
        run({5'd1, 11'd0, 16'hFFFF}, 32'd5, 32'd0);
        chk("addi_o", bus.o, 32'd4);
        chk("addi_c", bus.cout, 1'b1);
        chk("addi_wre", bus.write_reg_en, 1'b1);
        chk("addi_ir", bus.i_r, 1'b0);
        run({5'd0, 23'd0, 4'd11}, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
        run({5'd0, 23'd0, 4'd12}, 32'd0, 32'd0);
        chk("mfhi_o", bus.o, 32'hFFFF_FFFF);
        run({5'd0, 23'd0, 4'd13}, 32'd0, 32'd0);
        run({5'd8, 27'd0}, 32'd7, 32'd7);
        chk("beq_br", bus.br_inst, 1'b1);
        chk("beq_go", bus.alu_go_ahead, 1'b1);
        chk("beq_taken", bus.branch, 1'b1);
        run({5'd8, 27'd0}, 32'd7, 32'd8);
        chk("beq_not_taken", bus.branch, 1'b0);
        run({5'd16, 25'd0, 2'd0}, 32'h3F80_0000, 32'h4000_0000);
        chk("fadd_f0", bus.f0, 32'h4040_0000);
        run({5'd16, 25'd0, 2'd2}, 32'h3F80_0000, 32'h4000_0000);
        chk("fmul_f0", bus.f0, 32'h4000_0000);
        run({5'd16, 25'd0, 2'd1}, 32'h3F80_0000, 32'h3F80_0000);
        chk("fsub_zero", bus.f0, 32'd0);
        run({5'd16, 25'd0, 2'd0}, 32'h0000_0001, 32'h3F80_0000);
        chk("fadd_denorm", bus.f0, 32'h3F80_0000);
        run({5'd16, 25'd0, 2'd2}, 32'h7F00_0000, 32'hC000_0000);
        chk("fmul_inf", bus.f0, 32'hFF80_0000);
        run({5'd16, 25'd0, 2'd3}, 32'hBF80_0000, 32'h3F80_0000);
        chk("flt_true", bus.f0, 32'h3F80_0000);
        run({5'd16, 25'd0, 2'd1}, 32'h3F80_0000, 32'h3380_0000);
        chk("fsub_trunc", bus.f0, 32'h3F7F_FFFF);
        run({5'd0, 23'd0, 4'd1}, 32'd0, 32'd1);
        run({5'd0, 23'd0, 4'd8}, 32'h8000_0000, 32'd31);
        run({5'd10, 27'd0}, 32'hFFFF_FFFF, 32'd0);
        run({5'd31, 27'h7FF_FFFF}, 32'd3, 32'd4);
        for (int i = 0; i < 400; i++) begin
            opc = $urandom_range(0, 3) == 0 ? 5'($urandom) : ops[$urandom_range(0, 14)];
            if (opc == 5'd16) begin
                rs = rand_fp();
                rt = rand_fp();
            end else begin
                rs = $urandom_range(0, 2) == 0 ? 32'($urandom_range(0, 15)) : $urandom;
                rt = $urandom_range(0, 2) == 0 ? rs : $urandom;
            end
            run({opc, 27'($urandom)}, rs, rt);
        end
        run({5'd0, 23'd0, 4'd11}, 32'h1234_5678, 32'h8765_4321);
        run({5'd16, 25'd0, 2'd0}, 32'h3F80_0000, 32'h3F80_0000);
        rst = 1'b0;
        #1;
        chk("async_hi", bus.hi, 32'd0);
        chk("async_lo", bus.lo, 32'd0);
        chk("async_f0", bus.f0, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        m_f0 = 32'd0;
        #2 rst = 1'b1;
        run({5'd0, 23'd0, 4'd12}, 32'd0, 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
